// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// One digit is lit per REFRESH_DIV-cycle slot; all outputs are registered.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an_l,
  output logic [6:0]              segs_l,
  output logic                    dp_l
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         pcnt_r;
  logic [IW-1:0]         idx_r;
  logic [NUM_DIGITS-1:0] supp_s;
  logic                  all_zero_s;
  logic [3:0]            nib_s;
  logic                  dark_s;
  logic [NUM_DIGITS-1:0] an_nxt_s;
  logic [6:0]            segs_nxt_s;
  logic                  dp_nxt_s;

  function automatic logic [6:0] hex_enc(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Prescaler and digit index; a low enable freezes both, even on terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_r <= '0;
      idx_r  <= '0;
    end else if (en) begin
      if (pcnt_r == PCNT_LAST) begin
        pcnt_r <= '0;
        idx_r  <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
      end else begin
        pcnt_r <= pcnt_r + PW'(1);
        idx_r  <= idx_r;
      end
    end else begin
      pcnt_r <= pcnt_r;
      idx_r  <= idx_r;
    end
  end

  // Digit k (k>=1) is suppressed when it and every digit above it are zero.
  always_comb begin
    supp_s     = '0;
    all_zero_s = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero_s = all_zero_s & (data[4*k +: 4] == 4'h0);
      supp_s[k]  = lz_en & all_zero_s;
    end
  end

  // Decode the currently selected digit into next-cycle output values.
  always_comb begin
    nib_s      = data[{idx_r, 2'b00} +: 4];
    dark_s     = blank[idx_r] | supp_s[idx_r];
    an_nxt_s   = '1;
    segs_nxt_s = 7'h7F;
    dp_nxt_s   = 1'b1;
    if (en && !dark_s) begin
      an_nxt_s[idx_r] = 1'b0;
      segs_nxt_s      = hex_enc(nib_s);
      dp_nxt_s        = ~dp_in[idx_r];
    end else begin
      an_nxt_s   = '1;
      segs_nxt_s = 7'h7F;
      dp_nxt_s   = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_l   <= '1;
      segs_l <= 7'h7F;
      dp_l   <= 1'b1;
    end else begin
      an_l   <= an_nxt_s;
      segs_l <= segs_nxt_s;
      dp_l   <= dp_nxt_s;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: a slot-arithmetic reference model
// queues expected outputs, and an independent monitor compares every cycle.
module tb_sevenseg_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [4*ND-1:0] data;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] blank;
  logic          lz_en;
  logic [ND-1:0] an_l;
  logic [6:0]    segs_l;
  logic          dp_l;

  typedef struct {
    logic [ND-1:0] an;
    logic [6:0]    segs;
    logic          dp;
  } exp_t;

  exp_t q[$];
  exp_t got;
  int   total = 0;
  int   bad   = 0;
  int   t     = 0;   // enabled edges since reset release

  sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .en(en), .data(data), .dp_in(dp_in),
    .blank(blank), .lz_en(lz_en), .an_l(an_l), .segs_l(segs_l), .dp_l(dp_l)
  );

  always #5 clk = ~clk;

  // Push expected output for the coming edge, then advance to the next negedge.
  task automatic step();
    exp_t e;
    int d;
    logic [ND-1:0] onehot;
    e.an = '1; e.segs = 7'h7F; e.dp = 1'b1;
    if (rst) begin
      t = 0;
    end else if (en) begin
      d = (t / RD) % ND;
      if (!(blank[d] || (lz_en && d >= 1 && (data >> (4*d)) == 0))) begin
        onehot = ND'(1) << d;
        e.an   = ~onehot;
        e.segs = HEX[data[4*d +: 4]];
        e.dp   = ~dp_in[d];
      end
      t++;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset between edges and confirm the outputs go dark immediately.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    total++;
    if (an_l !== '1 || segs_l !== 7'h7F || dp_l !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: an_l=%h segs_l=%h dp_l=%b required an_l=%h segs_l=7f dp_l=1",
               an_l, segs_l, dp_l, {ND{1'b1}});
    end
    steps(2);
    rst = 1'b0;
  endtask

  // Monitor: pop one expectation per edge and check at most one anode is low.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      got = q.pop_front();
      total++;
      if (an_l !== got.an || segs_l !== got.segs || dp_l !== got.dp) begin
        bad++;
        $display("FAIL scan_out @%0t: an_l=%h segs_l=%h dp_l=%b required an_l=%h segs_l=%h dp_l=%b",
                 $time, an_l, segs_l, dp_l, got.an, got.segs, got.dp);
      end
    end
    total++;
    if ($countones(~an_l) > 1) begin
      bad++;
      $display("FAIL onehot_anode @%0t: an_l=%h required at most one low bit", $time, an_l);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; data = 16'h12AF; dp_in = '0; blank = '0; lz_en = 1'b0;
    @(negedge clk);
    steps(2);
    rst = 1'b0;

    // Basic rotation with wrap.
    steps(3 * ND * RD);

    // Reset during the second cycle of digit 2's slot.
    do_reset();
    steps(2 * RD + 1);
    do_reset();
    steps(ND * RD);

    // Leading-zero suppression.
    lz_en = 1'b1; data = 16'h0000;
    steps(ND * RD);
    data = 16'h0030;
    steps(ND * RD);
    lz_en = 1'b0; data = 16'h12AF;

    // Decimal point and blanking.
    dp_in = 4'b0100; blank = 4'b1000;
    steps(2 * ND * RD);
    dp_in = '0; blank = '0;

    // Enable drop at cycle 2 of digit 1's slot.
    do_reset();
    steps(RD + 2);
    en = 1'b0;
    steps(5);
    en = 1'b1;
    steps(2 * ND * RD);

    // Exhaustive encode on digit 0.
    for (int v = 0; v < 16; v++) begin
      data = {12'h000, 4'(v)};
      steps(ND * RD);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) data = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'h00FF : 16'hFFFF);
        if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
        if ($urandom_range(0, 7) == 0) blank = 4'($urandom) & 4'($urandom);
        if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
        en = ($urandom_range(0, 9) != 0);
        step();
      end
    end

    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: left=%0d required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
